ballot_unit: RTL and testbench
==============================

BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, meaning consecutive stable cycles required to accept a button press (range 2..255).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, meaning cycles IN stays valid after the Ballot pulse (range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning maximum armed wait before the ballot is voided (range 16..65535).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 The block SHALL have port Power  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port Ballot_en  input  1  polling-officer enable, asynchronous to clk.
REQ-007 The block SHALL have port Close  input  1  poll-closed level, synchronous to clk.
REQ-008 The block SHALL have port btn  input  15  raw candidate buttons, btn[k] selects candidate k+1, asynchronous and bouncing.
REQ-009 The block SHALL have port Ballot  output  1  one-cycle vote strobe to the voting machine.
REQ-010 The block SHALL have port IN  output  4  candidate code 1..15, 0 meaning no vote.
REQ-011 The block SHALL have port armed  output  1  high while a voter may press a button.
REQ-012 The block SHALL have port err  output  1  sticky multi-press indication for the current ballot.
REQ-013 The block SHALL have port timeout  output  1  one-cycle pulse when an armed ballot is voided.
REQ-014 The block SHALL have port votes  output  12  votes issued since reset, saturating.

Function
REQ-015 Ballot_en and btn SHALL pass through a 2-flop synchronizer; all rules below refer to synchronized values (2 cycles latency).
REQ-016 FSM states SHALL be IDLE, ARMED, DEBOUNCE, CAST, HOLD, RELEASE.
REQ-017 IDLE SHALL move to ARMED on a rising edge of synchronized Ballot_en when Close=0 and btn==0; otherwise it stays in IDLE.
REQ-018 ARMED SHALL drive armed=1, run the timeout counter, and set err when two or more btn bits are high.
REQ-019 ARMED SHALL move to DEBOUNCE and capture code k+1 when exactly one btn bit k is high.
REQ-020 DEBOUNCE SHALL require the same single bit for DB_CYCLES consecutive cycles; any change returns the FSM to ARMED with the debounce count cleared and the timeout count kept.
REQ-021 After DB_CYCLES stable cycles the FSM SHALL enter CAST; CAST SHALL last exactly 1 cycle with Ballot=1 and IN=code, and votes SHALL increment in that cycle, saturating at 4095.
REQ-022 HOLD SHALL drive IN=code and Ballot=0 for HOLD_CYCLES cycles, then move to RELEASE.
REQ-023 RELEASE SHALL drive IN=0 and wait until btn==0 for 2 consecutive cycles, then move to IDLE and clear err.
REQ-024 When the timeout count reaches TIMEOUT_CYCLES in ARMED or DEBOUNCE, the block SHALL pulse timeout for 1 cycle, issue no vote, and go to RELEASE.
REQ-025 Close=1 in ARMED or DEBOUNCE SHALL abort to IDLE with no vote and no timeout pulse; in CAST, HOLD or RELEASE it SHALL have no effect.
REQ-026 Close=1 SHALL block re-arming; Ballot_en held high SHALL NOT re-arm without a new rising edge.
REQ-027 Ballot SHALL never be high for 2 consecutive cycles, and IN SHALL be 0 in IDLE, ARMED, DEBOUNCE and RELEASE.
REQ-028 An armed-to-CAST cycle SHALL issue at most one vote per Ballot_en rising edge.

Reset
REQ-029 Power=1 SHALL immediately force: state IDLE; Ballot=0; IN=0; armed=0; err=0; timeout=0; votes=0; synchronizers, counters and code cleared.
REQ-030 Power asserted mid-operation, including CAST, SHALL discard the ballot; a partially issued strobe SHALL NOT be counted.
REQ-031 Reset deassertion SHALL be synchronized externally; after release the block SHALL require a fresh Ballot_en edge.

Structure
REQ-032 A shared package vote_pkg SHALL hold the FSM state enum, candidate code width (4), count width (12) and NUM_CAND=15, for reuse by the voting machine.
REQ-033 One sub-module btn_sync (parameterized-width 2-flop synchronizer with async reset) SHALL be instantiated for {Ballot_en, btn}.

Verification
REQ-034 Ballot_en edge, btn[4] steady 20 cycles (DB_CYCLES=16) -> single Ballot pulse with IN=5, IN=5 for 4 further cycles, votes=1.
REQ-035 btn[2] bouncing (toggle every 3 cycles for 12 cycles) then stable -> exactly one Ballot with IN=3, no strobe during the bounce.
REQ-036 btn[0] and btn[14] pressed together for 30 cycles -> err=1, no Ballot; release then btn[1] held -> Ballot with IN=2, err cleared on IDLE.
REQ-037 Armed with no press for 1024 cycles -> timeout pulse, no Ballot, votes unchanged; button held afterwards -> no vote until a new Ballot_en edge.
REQ-038 Close=1 during DEBOUNCE -> IDLE with no vote; Power pulsed during HOLD -> all outputs 0 and votes=0 on the same edge.
REQ-039 4100 complete ballots -> votes saturates at 4095, each ballot still strobes Ballot once.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared voting types, widths and button decode helpers; purely combinational.
// No latency, no backpressure: reused by the voting machine side.
package vote_pkg;
  localparam int CODE_W   = 4;
  localparam int CNT_W    = 12;
  localparam int NUM_CAND = 15;

  localparam logic [CNT_W-1:0]    VOTES_MAX = '1;
  localparam logic [NUM_CAND-1:0] BTN_ONE   = NUM_CAND'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DEBOUNCE,
    CAST,
    HOLD,
    RELEASE
  } state_e;

  function automatic logic btn_single(input logic [NUM_CAND-1:0] b);
    return (b != '0) && ((b & (b - BTN_ONE)) == '0);
  endfunction

  function automatic logic btn_multi(input logic [NUM_CAND-1:0] b);
    return (b & (b - BTN_ONE)) != '0;
  endfunction

  // Candidate code of the highest pressed button; only meaningful for a single press.
  function automatic logic [CODE_W-1:0] btn_code(input logic [NUM_CAND-1:0] b);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (b[k]) c = CODE_W'(k + 1);
    end
    return c;
  endfunction
endpackage

// File: rtl/ballot_unit_if.sv
// Officer/voter inputs and machine-facing outputs of the ballot unit.
// Plain wires, no latency; the unit never stalls its inputs.
interface ballot_unit_if;
  import vote_pkg::*;

  logic                Ballot_en;
  logic                Close;
  logic [NUM_CAND-1:0] btn;
  logic                Ballot;
  logic [CODE_W-1:0]   IN;
  logic                armed;
  logic                err;
  logic                timeout;
  logic [CNT_W-1:0]    votes;

  modport master (
    output Ballot_en, Close, btn,
    input  Ballot, IN, armed, err, timeout, votes
  );

  modport slave (
    input  Ballot_en, Close, btn,
    output Ballot, IN, armed, err, timeout, votes
  );
endinterface

// File: rtl/btn_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous clear.
// Latency 2 cycles, no backpressure.
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ballot_unit.sv
// Arms on an officer edge, debounces one candidate button, strobes one vote, then holds and releases.
// Inputs see 2 cycles of synchronizer latency; no backpressure, the machine must accept every strobe.
module ballot_unit
  import vote_pkg::*;
#(
  parameter int DB_CYCLES      = 16,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          Power,
  ballot_unit_if.slave bus
);
  localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic                be_s;
  logic [NUM_CAND-1:0] btn_s;

  btn_sync #(.WIDTH(NUM_CAND + 1)) u_sync (
    .clk (clk),
    .rst (Power),
    .d_i ({bus.Ballot_en, bus.btn}),
    .q_o ({be_s, btn_s})
  );

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  votes_q, votes_d;
  logic [1:0]        prime_q;
  logic              be_prev_q;
  logic              be_rise;

  // prev starts high and edges are ignored until the synchronizer has filled,
  // so an enable held high across reset never looks like a fresh edge.
  assign be_rise = prime_q[1] & be_s & ~be_prev_q;

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      code_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      votes_q   <= '0;
      prime_q   <= '0;
      be_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      code_q    <= code_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      votes_q   <= votes_d;
      prime_q   <= {prime_q[0], 1'b1};
      be_prev_q <= prime_q[1] ? be_s : 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    err_d     = err_q;
    timeout_d = 1'b0;
    votes_d   = votes_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (be_rise && !bus.Close && (btn_s == '0)) begin
          state_d = ARMED;
          tmo_d   = '0;
          cnt_d   = '0;
        end
      end
      ARMED, DEBOUNCE: begin
        if (bus.Close) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (state_q == ARMED) begin
            if (btn_multi(btn_s)) err_d = 1'b1;
            if (btn_single(btn_s)) begin
              state_d = DEBOUNCE;
              code_d  = btn_code(btn_s);
              cnt_d   = '0;
            end
          end else if (!(btn_single(btn_s) && (btn_code(btn_s) == code_q))) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = CAST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      CAST: begin
        state_d = HOLD;
        cnt_d   = '0;
        if (votes_q != VOTES_MAX) votes_d = votes_q + CNT_W'(1);
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (btn_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == 8'd1) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Ballot  = (state_q == CAST);
  assign bus.IN      = ((state_q == CAST) || (state_q == HOLD)) ? code_q : '0;
  assign bus.armed   = (state_q == ARMED) || (state_q == DEBOUNCE);
  assign bus.err     = err_q;
  assign bus.timeout = timeout_q;
  assign bus.votes   = votes_q;
endmodule

// File: tb/tb_ballot_unit.sv
// Scenario bench for ballot_unit: default-parameter instance for behaviour, short-parameter instance for saturation.
module tb_ballot_unit;
  import vote_pkg::*;

  localparam int DB   = 16;
  localparam int HOLD = 4;
  localparam int TMO  = 1024;

  logic clk = 1'b0;
  logic Power;
  always #5 clk = ~clk;

  ballot_unit_if bif ();
  ballot_unit_if sif ();

  ballot_unit dut (.clk(clk), .Power(Power), .bus(bif.slave));
  ballot_unit #(.DB_CYCLES(2), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(16)) dut_sat (
    .clk(clk), .Power(Power), .bus(sif.slave));

  int checks = 0;
  int failures = 0;
  int model_votes = 0;

  int ballot_pulses = 0, tmo_pulses = 0, dbl_ballot = 0, dbl_tmo = 0, in_bad = 0;
  int since_ballot = 1000;
  int sat_pulses = 0, sat_dbl = 0;
  logic prev_b = 1'b0, prev_t = 1'b0, sat_prev = 1'b0;

  // Observes protocol properties independent of any scenario.
  always @(negedge clk) begin
    if (Power) begin
      prev_b = 1'b0; prev_t = 1'b0; sat_prev = 1'b0; since_ballot = 1000;
    end else begin
      if (bif.Ballot) begin
        ballot_pulses++;
        if (prev_b) dbl_ballot++;
        since_ballot = 0;
      end else if (since_ballot < 1000) begin
        since_ballot++;
      end
      if (bif.timeout) begin
        tmo_pulses++;
        if (prev_t) dbl_tmo++;
      end
      if (bif.IN != '0 && since_ballot > HOLD) in_bad++;
      prev_b = bif.Ballot;
      prev_t = bif.timeout;
      if (sif.Ballot) begin
        sat_pulses++;
        if (sat_prev) sat_dbl++;
      end
      sat_prev = sif.Ballot;
    end
  end

  function automatic int sat_votes(input int n);
    return (n > 4095) ? 4095 : n;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm();
    bif.Ballot_en = 1'b0;
    tick(3);
    bif.Ballot_en = 1'b1;
    tick(4);
  endtask

  task automatic release_all();
    bif.btn = '0;
    bif.Ballot_en = 1'b0;
    tick(8);
  endtask

  task automatic wait_strobe(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bif.Ballot) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Power = 1'b1;
    bif.Ballot_en = 1'b0; bif.Close = 1'b0; bif.btn = '0;
    sif.Ballot_en = 1'b0; sif.Close = 1'b0; sif.btn = '0;
    tick(3);
    checks++; if (bif.Ballot !== 1'b0) begin failures++; $display("FAIL reset_Ballot got=%0b exp=0", bif.Ballot); end
    checks++; if (bif.IN !== 4'd0) begin failures++; $display("FAIL reset_IN got=%0d exp=0", bif.IN); end
    checks++; if (bif.armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", bif.armed); end
    checks++; if (bif.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bif.err); end
    checks++; if (bif.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", bif.timeout); end
    checks++; if (bif.votes !== 12'd0) begin failures++; $display("FAIL reset_votes got=%0d exp=0", bif.votes); end
    Power = 1'b0;
    tick(4);
  endtask

  task automatic test_single_vote(input int k);
    bit seen;
    int p0;
    p0 = ballot_pulses;
    arm();
    checks++; if (bif.armed !== 1'b1) begin failures++; $display("FAIL vote_armed k=%0d got=%0b exp=1", k, bif.armed); end
    bif.btn = '0;
    bif.btn[k] = 1'b1;
    wait_strobe(40, seen);
    checks++; if (!seen) begin failures++; $display("FAIL vote_strobe k=%0d got=none exp=pulse", k); end
    checks++; if (bif.IN !== 4'(k + 1)) begin failures++; $display("FAIL vote_IN k=%0d got=%0d exp=%0d", k, bif.IN, k + 1); end
    model_votes++;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      checks++; if (bif.Ballot !== 1'b0 || bif.IN !== 4'(k + 1)) begin
        failures++; $display("FAIL vote_hold%0d got=Ballot%0b/IN%0d exp=Ballot0/IN%0d", i, bif.Ballot, bif.IN, k + 1);
      end
    end
    tick();
    checks++; if (bif.IN !== 4'd0) begin failures++; $display("FAIL vote_release_IN got=%0d exp=0", bif.IN); end
    checks++; if (bif.votes !== 12'(sat_votes(model_votes))) begin failures++; $display("FAIL vote_votes got=%0d exp=%0d", bif.votes, sat_votes(model_votes)); end
    release_all();
    checks++; if (ballot_pulses - p0 !== 1) begin failures++; $display("FAIL vote_pulse_count got=%0d exp=1", ballot_pulses - p0); end
    checks++; if (bif.armed !== 1'b0) begin failures++; $display("FAIL vote_idle_armed got=%0b exp=0", bif.armed); end
  endtask

  task automatic test_bounce(input int k, input int period, input int toggles);
    bit seen;
    int p0;
    p0 = ballot_pulses;
    arm();
    bif.btn = '0;
    for (int t = 0; t < toggles; t++) begin
      bif.btn[k] = ~bif.btn[k];
      tick(period);
    end
    checks++; if (ballot_pulses !== p0) begin failures++; $display("FAIL bounce_early got=%0d exp=0 pulses", ballot_pulses - p0); end
    bif.btn[k] = 1'b1;
    wait_strobe(40, seen);
    checks++; if (!seen || bif.IN !== 4'(k + 1)) begin failures++; $display("FAIL bounce_vote seen=%0b IN=%0d exp=%0d", seen, bif.IN, k + 1); end
    model_votes++;
    release_all();
    checks++; if (ballot_pulses - p0 !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", ballot_pulses - p0); end
  endtask

  task automatic test_multi();
    bit seen;
    int p0;
    p0 = ballot_pulses;
    arm();
    bif.btn = '0;
    bif.btn[0] = 1'b1;
    bif.btn[14] = 1'b1;
    tick(30);
    checks++; if (bif.err !== 1'b1) begin failures++; $display("FAIL multi_err got=%0b exp=1", bif.err); end
    checks++; if (ballot_pulses !== p0) begin failures++; $display("FAIL multi_no_vote got=%0d exp=0", ballot_pulses - p0); end
    bif.btn = '0;
    tick(3);
    bif.btn[1] = 1'b1;
    wait_strobe(40, seen);
    checks++; if (!seen || bif.IN !== 4'd2) begin failures++; $display("FAIL multi_vote seen=%0b IN=%0d exp=2", seen, bif.IN); end
    model_votes++;
    tick(2);
    checks++; if (bif.err !== 1'b1) begin failures++; $display("FAIL multi_err_sticky got=%0b exp=1", bif.err); end
    release_all();
    checks++; if (bif.err !== 1'b0) begin failures++; $display("FAIL multi_err_clear got=%0b exp=0", bif.err); end
    checks++; if (bif.votes !== 12'(sat_votes(model_votes))) begin failures++; $display("FAIL multi_votes got=%0d exp=%0d", bif.votes, sat_votes(model_votes)); end
  endtask

  task automatic test_timeout();
    int n, p0, t0;
    p0 = ballot_pulses;
    t0 = tmo_pulses;
    bif.btn = '0;
    bif.Ballot_en = 1'b0;
    tick(3);
    bif.Ballot_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bif.armed) break;
    end
    n = bif.armed ? 1 : 0;
    for (int i = 0; i < TMO + 100 && n > 0; i++) begin
      tick();
      if (bif.armed) n++; else break;
    end
    checks++; if (n !== TMO) begin failures++; $display("FAIL tmo_armed_cycles got=%0d exp=%0d", n, TMO); end
    checks++; if (bif.timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%0b exp=1", bif.timeout); end
    tick();
    checks++; if (bif.timeout !== 1'b0) begin failures++; $display("FAIL tmo_width got=%0b exp=0", bif.timeout); end
    checks++; if (tmo_pulses - t0 !== 1) begin failures++; $display("FAIL tmo_count got=%0d exp=1", tmo_pulses - t0); end
    bif.btn[6] = 1'b1;
    tick(60);
    bif.btn = '0;
    tick(10);
    bif.btn[6] = 1'b1;
    tick(30);
    checks++; if (ballot_pulses !== p0 || bif.armed !== 1'b0) begin
      failures++; $display("FAIL tmo_no_rearm pulses=%0d armed=%0b exp=0/0", ballot_pulses - p0, bif.armed);
    end
    checks++; if (bif.votes !== 12'(sat_votes(model_votes))) begin failures++; $display("FAIL tmo_votes got=%0d exp=%0d", bif.votes, sat_votes(model_votes)); end
    release_all();
  endtask

  task automatic test_close();
    int p0, t0;
    p0 = ballot_pulses;
    t0 = tmo_pulses;
    arm();
    bif.btn = '0;
    bif.btn[7] = 1'b1;
    tick(6);
    checks++; if (bif.armed !== 1'b1) begin failures++; $display("FAIL close_pre_armed got=%0b exp=1", bif.armed); end
    bif.Close = 1'b1;
    tick();
    checks++; if (bif.armed !== 1'b0) begin failures++; $display("FAIL close_abort got=%0b exp=0", bif.armed); end
    tick(30);
    checks++; if (ballot_pulses !== p0 || tmo_pulses !== t0) begin
      failures++; $display("FAIL close_no_vote pulses=%0d timeouts=%0d exp=0/0", ballot_pulses - p0, tmo_pulses - t0);
    end
    bif.btn = '0;
    bif.Ballot_en = 1'b0;
    tick(3);
    bif.Ballot_en = 1'b1;
    tick(5);
    checks++; if (bif.armed !== 1'b0) begin failures++; $display("FAIL close_blocks_arm got=%0b exp=0", bif.armed); end
    bif.Close = 1'b0;
    tick(5);
    checks++; if (bif.armed !== 1'b0) begin failures++; $display("FAIL close_held_en got=%0b exp=0", bif.armed); end
    release_all();
  endtask

  task automatic test_power_hold();
    bit seen;
    arm();
    bif.btn = '0;
    bif.btn[9] = 1'b1;
    wait_strobe(40, seen);
    tick(2);
    checks++; if (bif.IN !== 4'd10) begin failures++; $display("FAIL pwr_in_hold got=%0d exp=10", bif.IN); end
    #2;
    Power = 1'b1;
    #1;
    checks++; if ({bif.Ballot, bif.armed, bif.err, bif.timeout} !== 4'b0 || bif.IN !== 4'd0 || bif.votes !== 12'd0) begin
      failures++; $display("FAIL pwr_async got=B%0b/A%0b/E%0b/T%0b/IN%0d/V%0d exp=all0",
        bif.Ballot, bif.armed, bif.err, bif.timeout, bif.IN, bif.votes);
    end
    model_votes = 0;
    bif.btn = '0;
    bif.Ballot_en = 1'b0;
    tick(2);
    Power = 1'b0;
    tick(4);
  endtask

  task automatic test_saturate();
    int p0;
    bit seen;
    p0 = sat_pulses;
    for (int n = 1; n <= 4100; n++) begin
      sif.Ballot_en = 1'b1;
      tick();
      sif.btn[3] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (sif.Ballot) begin seen = 1'b1; break; end
      end
      checks++; if (!seen || sif.IN !== 4'd4) begin failures++; $display("FAIL sat_strobe n=%0d seen=%0b IN=%0d exp=4", n, seen, sif.IN); end
      sif.btn = '0;
      sif.Ballot_en = 1'b0;
      tick(6);
      checks++; if (sif.votes !== 12'(sat_votes(n))) begin failures++; $display("FAIL sat_votes n=%0d got=%0d exp=%0d", n, sif.votes, sat_votes(n)); end
    end
    checks++; if (sat_pulses - p0 !== 4100) begin failures++; $display("FAIL sat_pulses got=%0d exp=4100", sat_pulses - p0); end
  endtask

  task automatic test_invariants();
    checks++; if (dbl_ballot !== 0 || sat_dbl !== 0) begin failures++; $display("FAIL inv_ballot_double got=%0d/%0d exp=0", dbl_ballot, sat_dbl); end
    checks++; if (dbl_tmo !== 0) begin failures++; $display("FAIL inv_timeout_width got=%0d exp=0", dbl_tmo); end
    checks++; if (in_bad !== 0) begin failures++; $display("FAIL inv_IN_outside_hold got=%0d exp=0", in_bad); end
  endtask

  initial begin
    test_reset();
    test_single_vote(4);
    for (int r = 0; r < 4; r++) test_single_vote(int'($urandom_range(0, 14)));
    test_bounce(2, 3, 4);
    for (int r = 0; r < 3; r++)
      test_bounce(int'($urandom_range(0, 14)), int'($urandom_range(1, 6)), int'($urandom_range(2, 6)));
    test_multi();
    test_timeout();
    test_single_vote(int'($urandom_range(0, 14)));
    test_close();
    test_power_hold();
    test_single_vote(int'($urandom_range(0, 14)));
    test_saturate();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
